ldst_sequencer: RTL

Sequences the single data-memory access of every Frost32 load/store instruction (group 3: ldr, ldh, ldsh, ldb, ldsb, str, sth, stb). It sits between the execute stage and the data-memory bus. It accepts a decoded load/store type, an effective address and store data, and runs a req/ack transaction with the correct byte lanes. It then returns a zero- or sign-extended load result for register writeback, and holds `busy` high so the pipeline stalls for the whole access.

---
 rtl/ldst_sequencer.sv | 156 +++++++++++++++
 1 files changed

// File: rtl/ldst_sequencer.sv
// rtl/ldst_sequencer.sv - single-access load/store sequencer between execute and the data-memory bus
module ldst_sequencer #(
    parameter int ADDR_WIDTH = 32
) (
    input  logic                  clk_i,
    input  logic                  rst_n_i,
    input  logic                  start_i,
    input  logic [2:0]            ldst_type_i,
    input  logic [ADDR_WIDTH-1:0] addr_i,
    input  logic [31:0]           wr_data_i,
    input  logic [3:0]            dest_index_i,
    output logic                  busy_o,
    output logic                  done_o,
    output logic                  misaligned_o,
    output logic                  rd_wr_en_o,
    output logic [3:0]            rd_index_o,
    output logic [31:0]           rd_data_o,
    output logic                  mem_req_o,
    output logic                  mem_we_o,
    output logic [ADDR_WIDTH-1:0] mem_addr_o,
    output logic [3:0]            mem_byte_en_o,
    output logic [31:0]           mem_wdata_o,
    input  logic [31:0]           mem_rdata_i,
    input  logic                  mem_ack_i
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_REQ   = 2'd1,
        S_DONE  = 2'd2,
        S_FAULT = 2'd3
    } state_t;

    // Type encoding: 0 Ld32, 1 LdU16, 2 LdS16, 3 LdU8, 4 LdS8, 5 St32, 6 St16, 7 St8
    function automatic logic is_store(input logic [2:0] t);
        return t[2] & (t[1] | t[0]);
    endfunction

    function automatic logic is_word(input logic [2:0] t);
        return (t == 3'd0) || (t == 3'd5);
    endfunction

    function automatic logic is_half(input logic [2:0] t);
        return (t == 3'd1) || (t == 3'd2) || (t == 3'd6);
    endfunction

    state_t                  state_q, state_d;
    logic [2:0]              type_q, type_d;
    logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
    logic [31:0]             wdata_q, wdata_d;
    logic [3:0]              rd_index_q, rd_index_d;
    logic [31:0]             rd_data_q, rd_data_d;

    logic                    misaligned_in;
    logic [15:0]             lane16;
    logic [7:0]              lane8;
    logic [31:0]             load_val;
    logic [3:0]              byte_en;
    logic [31:0]             store_data;

    assign misaligned_in = (is_half(ldst_type_i) && addr_i[0]) ||
                           (is_word(ldst_type_i) && (addr_i[1:0] != 2'b00));

    always_comb begin
        lane16 = addr_q[1] ? mem_rdata_i[31:16] : mem_rdata_i[15:0];
        lane8  = 8'h00;
        case (addr_q[1:0])
            2'd0:    lane8 = mem_rdata_i[7:0];
            2'd1:    lane8 = mem_rdata_i[15:8];
            2'd2:    lane8 = mem_rdata_i[23:16];
            default: lane8 = mem_rdata_i[31:24];
        endcase
        case (type_q)
            3'd0:    load_val = mem_rdata_i;
            3'd1:    load_val = {16'h0000, lane16};
            3'd2:    load_val = {{16{lane16[15]}}, lane16};
            3'd3:    load_val = {24'h000000, lane8};
            3'd4:    load_val = {{24{lane8[7]}}, lane8};
            default: load_val = rd_data_q;
        endcase
    end

    always_comb begin
        if (is_word(type_q)) begin
            byte_en    = 4'b1111;
            store_data = wdata_q;
        end else if (is_half(type_q)) begin
            byte_en    = addr_q[1] ? 4'b1100 : 4'b0011;
            store_data = {2{wdata_q[15:0]}};
        end else begin
            byte_en    = 4'b0001 << addr_q[1:0];
            store_data = {4{wdata_q[7:0]}};
        end
    end

    always_comb begin
        state_d    = state_q;
        type_d     = type_q;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        rd_index_d = rd_index_q;
        rd_data_d  = rd_data_q;
        case (state_q)
            S_IDLE: begin
                if (start_i) begin
                    type_d     = ldst_type_i;
                    addr_d     = addr_i;
                    wdata_d    = wr_data_i;
                    rd_index_d = dest_index_i;
                    state_d    = misaligned_in ? S_FAULT : S_REQ;
                end
            end
            S_REQ: begin
                if (mem_ack_i) begin
                    state_d = S_DONE;
                    if (!is_store(type_q)) begin
                        rd_data_d = load_val;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q    <= S_IDLE;
            type_q     <= 3'd0;
            addr_q     <= '0;
            wdata_q    <= 32'h0;
            rd_index_q <= 4'h0;
            rd_data_q  <= 32'h0;
        end else begin
            state_q    <= state_d;
            type_q     <= type_d;
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
            rd_index_q <= rd_index_d;
            rd_data_q  <= rd_data_d;
        end
    end

    // Bus and status outputs are decoded from state so they collapse to 0 the moment reset asserts
    assign busy_o        = (state_q != S_IDLE);
    assign done_o        = (state_q == S_DONE) || (state_q == S_FAULT);
    assign misaligned_o  = (state_q == S_FAULT);
    assign rd_wr_en_o    = (state_q == S_DONE) && !is_store(type_q);
    assign rd_index_o    = rd_index_q;
    assign rd_data_o     = rd_data_q;
    assign mem_req_o     = (state_q == S_REQ);
    assign mem_we_o      = mem_req_o && is_store(type_q);
    assign mem_addr_o    = mem_req_o ? {addr_q[ADDR_WIDTH-1:2], 2'b00} : '0;
    assign mem_byte_en_o = mem_req_o ? byte_en : 4'b0000;
    assign mem_wdata_o   = mem_we_o ? store_data : 32'h0;

endmodule
